// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and immediate decoders for the PipelinedCPU.
// Used by fetch_unit (optional macro FETCH_STATIC_PREDICT_EN).
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/instruction_rom.sv
// Word-addressed instruction ROM with combinational read and range flag.
// Contents are preloaded by the environment into rom_memory.
module instruction_rom
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 1024
) (
   input  logic [XLEN-3:0] word_index,
   output logic [31:0]     data,
   output logic            out_of_range
);

   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   logic [31:0] rom_memory [IMEM_DEPTH];

   always_comb begin
      out_of_range = 64'(word_index) >= 64'(IMEM_DEPTH);
      data         = NOP_INSTR;
      if (!out_of_range)
         data = rom_memory[word_index[AW-1:0]];
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ROM read and IF/ID register.
// Optional static branch predictor under macro FETCH_STATIC_PREDICT_EN.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int               XLEN       = riscv_pkg::XLEN,
   parameter int               IMEM_DEPTH = 1024,
   parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   input  logic            stall_id,
   input  logic            flush_id,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instruction,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [31:0]     if_id_instruction,
   output logic            if_id_valid,
   output logic            if_id_pred_taken,
   output logic [31:0]     fetch_count,
   output logic            imem_fault
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pred_target;
   logic            pred_taken;
   logic            rom_oor;
   logic            bad_redirect;
   logic            bubble;
   logic            load;

   assign if_pc    = pc_q;
   assign pc_plus4 = pc_q + XLEN'(4);

   instruction_rom #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) imem_inst (
      .word_index   (pc_q[XLEN-1:2]),
      .data         (if_instruction),
      .out_of_range (rom_oor)
   );

`ifdef FETCH_STATIC_PREDICT_EN
   logic [6:0]  opcode;
   logic [31:0] imm;

   // Backward branches and all JALs are guessed taken; EX fixes misses.
   always_comb begin
      opcode     = if_instruction[6:0];
      pred_taken = 1'b0;
      imm        = '0;
      if (opcode == OP_JAL) begin
         pred_taken = 1'b1;
         imm        = imm_j(if_instruction);
      end else if (opcode == OP_BRANCH && if_instruction[31]) begin
         pred_taken = 1'b1;
         imm        = imm_b(if_instruction);
      end
      pred_target = (pc_q + XLEN'($signed(imm))) & ~XLEN'(3);
   end
`else
   assign pred_taken  = 1'b0;
   assign pred_target = pc_plus4;
`endif

   always_comb begin
      pc_next = pc_plus4;
      if (redirect_valid)
         pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      else if (stall_if)
         pc_next = pc_q;
      else if (pred_taken)
         pc_next = pred_target;
   end

   assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign bubble       = flush_id | redirect_valid;
   assign load         = !bubble && !stall_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_pc          <= '0;
         if_id_pc_plus4    <= '0;
         if_id_instruction <= NOP_INSTR;
         if_id_valid       <= 1'b0;
         if_id_pred_taken  <= 1'b0;
      end else if (bubble) begin
         if_id_pc          <= '0;
         if_id_pc_plus4    <= '0;
         if_id_instruction <= NOP_INSTR;
         if_id_valid       <= 1'b0;
         if_id_pred_taken  <= 1'b0;
      end else if (load) begin
         if_id_pc          <= pc_q;
         if_id_pc_plus4    <= pc_plus4;
         if_id_instruction <= if_instruction;
         if_id_valid       <= 1'b1;
         if_id_pred_taken  <= pred_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_count <= '0;
      else if (load && fetch_count != 32'hFFFF_FFFF)
         fetch_count <= fetch_count + 32'd1;
   end

   // Sticky: reported to the trap logic, fetch itself keeps going.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         imem_fault <= 1'b0;
      else if (rom_oor || bad_redirect)
         imem_fault <= 1'b1;
   end

endmodule
